// File: rtl/picosoc_memctl.sv
// picosoc_memctl: memory/peripheral slave for the picorv32 native bus.
//
// Decodes each CPU access to on-chip RAM, a 16-byte GPIO register window,
// the external memory port (SPI flash controller) or nothing. RAM and GPIO
// complete one cycle after the request. EXT completion is passed straight
// through from xmem_ready. Anything still pending after TIMEOUT cycles is
// force-completed with ERR_RDATA, and the sticky bus_err flag is set.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb CPU request (wstrb==0 means read)
//   mem_ready/rdata            completion pulse and read data
//   xmem_valid/addr            external request
//   xmem_ready/rdata           external completion
//   gpio_i/o/oe                pins (gpio_i is asynchronous)
//   bus_err                    sticky timeout flag
//   irq                        GPIO interrupt
//
// Optional feature: define PICOSOC_GPIO_IRQ_EN to enable the GPIO rising-edge
// interrupt (IRQ_STAT at +0x8, IRQ_MASK at +0xC). Without it, those registers
// read 0 and irq is tied low.

module picosoc_memctl #(
    parameter int          MEM_WORDS  = 256,
    parameter int          GPIO_WIDTH = 32,
    parameter logic [31:0] GPIO_BASE  = 32'hC000_0000,
    parameter int          TIMEOUT    = 64,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  xmem_valid,
    output logic [23:0]           xmem_addr,
    input  logic                  xmem_ready,
    input  logic [31:0]           xmem_rdata,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  bus_err,
    output logic                  irq
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(TIMEOUT + 1);

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] strb);
        logic [31:0] m;
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~m) | (wd & m);
    endfunction

    logic [31:0]           ram [MEM_WORDS];
    logic [31:0]           ram_rd, gpio_rd, rdata_q;
    logic                  is_ram, is_gpio, is_ext;
    logic                  ready_q, tmo_q, ext_ready, start, fire;
    logic [CW-1:0]         cnt;
    logic [GPIO_WIDTH-1:0] sync1, sync2;
    logic [AW-1:0]         idx;

    // Decode is priority-ordered so the targets stay exclusive even if a
    // parameter choice makes two windows overlap.
    always_comb begin
        is_ram  = mem_addr < 32'(4 * MEM_WORDS);
        is_gpio = !is_ram && (mem_addr[31:4] == GPIO_BASE[31:4]);
        is_ext  = !is_ram && !is_gpio && (mem_addr[31:30] == 2'b10);
    end

    assign idx        = mem_addr[AW+1:2];
    assign ram_rd     = ram[idx];
    assign ext_ready  = mem_valid && is_ext && xmem_ready;
    // tmo_q and ext_ready can coincide; ext data then takes priority below.
    assign mem_ready  = ready_q || tmo_q || ext_ready;
    assign mem_rdata  = ext_ready ? xmem_rdata : rdata_q;
    assign xmem_valid = mem_valid && is_ext && !mem_ready;
    assign xmem_addr  = mem_addr[23:0];

    // start: first cycle of a local (RAM/GPIO) access. ready_q blocks a
    // second start while the CPU still holds valid in the completion cycle.
    assign start = mem_valid && !mem_ready && (is_ram || is_gpio);
    assign fire  = mem_valid && !mem_ready && (cnt == CW'(TIMEOUT - 1));

`ifdef PICOSOC_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] sync3, irq_stat, irq_mask, w1c;
    logic                  irq_q;

    assign w1c = (start && is_gpio && mem_addr[3:2] == 2'd2)
                 ? GPIO_WIDTH'(wmerge(32'h0, mem_wdata, mem_wstrb)) : '0;
    assign irq = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync3    <= '0;
            irq_stat <= '0;
            irq_mask <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync3    <= sync2;
            // A fresh edge wins over a simultaneous W1C of the same bit.
            irq_stat <= (irq_stat & ~w1c) | (sync2 & ~sync3);
            irq_q    <= |(irq_stat & irq_mask);
            if (start && is_gpio && mem_addr[3:2] == 2'd3)
                irq_mask <= GPIO_WIDTH'(wmerge(32'(irq_mask), mem_wdata, mem_wstrb));
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        gpio_rd = '0;
        case (mem_addr[3:2])
            2'd0: gpio_rd = 32'(sync2);
            2'd1: gpio_rd = 32'(gpio_oe);
`ifdef PICOSOC_GPIO_IRQ_EN
            2'd2: gpio_rd = 32'(irq_stat);
            2'd3: gpio_rd = 32'(irq_mask);
`endif
            default: gpio_rd = '0;
        endcase
    end

    // RAM contents survive reset; only the write is suppressed during it.
    always_ff @(posedge clk) begin
        if (!reset && start && is_ram) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) ram[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            tmo_q   <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            bus_err <= 1'b0;
            gpio_o  <= '0;
            gpio_oe <= '0;
            sync1   <= '0;
            sync2   <= '0;
        end else begin
            sync1   <= gpio_i;
            sync2   <= sync1;
            ready_q <= start;
            tmo_q   <= fire;
            cnt     <= (mem_valid && !mem_ready) ? cnt + 1'b1 : '0;
            if (start)     rdata_q <= is_ram ? ram_rd : gpio_rd;
            if (fire)      rdata_q <= ERR_RDATA;
            if (ext_ready) rdata_q <= xmem_rdata;
            if (tmo_q && !ext_ready) bus_err <= 1'b1;
            if (start && is_gpio && mem_addr[3:2] == 2'd0)
                gpio_o  <= GPIO_WIDTH'(wmerge(32'(gpio_o), mem_wdata, mem_wstrb));
            if (start && is_gpio && mem_addr[3:2] == 2'd1)
                gpio_oe <= GPIO_WIDTH'(wmerge(32'(gpio_oe), mem_wdata, mem_wstrb));
        end
    end
endmodule

// File: tb/tb_picosoc_memctl.sv
// Self-checking bench for picosoc_memctl: directed cases plus randomized
// accesses compared against a transaction-level model of the memory map.
module tb_picosoc_memctl;
    localparam int          TMO = 64;
    localparam logic [31:0] GB  = 32'hC000_0000;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 0, reset = 1;
    logic        mem_valid = 0, xmem_ready = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0, xmem_rdata = 0;
    logic [3:0]  mem_wstrb = 0;
    logic [31:0] gpio_i = 0;
    logic        mem_ready, xmem_valid, bus_err, irq;
    logic [31:0] mem_rdata, gpio_o, gpio_oe;
    logic [23:0] xmem_addr;

    always #5 clk = ~clk;

    picosoc_memctl dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .xmem_valid(xmem_valid), .xmem_addr(xmem_addr),
        .xmem_ready(xmem_ready), .xmem_rdata(xmem_rdata), .gpio_i(gpio_i),
        .gpio_o(gpio_o), .gpio_oe(gpio_oe), .bus_err(bus_err), .irq(irq)
    );

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion-pulse monitor: counts pulses and back-to-back pulses.
    int   rdy_cnt = 0, dbl = 0;
    logic prev_rdy = 0;
    always begin
        @(negedge clk); #2;
        if (mem_ready === 1'b1) begin
            rdy_cnt++;
            if (prev_rdy) dbl++;
        end
        prev_rdy = (mem_ready === 1'b1);
    end

    // Reference model state
    logic [31:0] m_ram [16];
    logic [31:0] m_gpo = 0, m_oe = 0, m_mask = 0;
    logic        m_err = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // One CPU access. xd<0: no external responder; otherwise xmem_ready is
    // raised in cycle xd+1 (cycle 1 = first cycle valid is high).
    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input int xd, input logic [31:0] xdat,
                            output logic [31:0] rd, output int lat, output int xv);
        bit done = 0;
        @(posedge clk); #1;
        mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = st; xmem_rdata = xdat;
        lat = 0; xv = 0; rd = 'x;
        while (!done && lat < 200) begin
            @(negedge clk); lat++;
            xmem_ready = (xd >= 0 && lat == xd + 1);
            #1;
            if (xmem_valid === 1'b1) xv++;
            if (mem_ready === 1'b1) begin rd = mem_rdata; done = 1; end
        end
        @(posedge clk); #1;
        mem_valid = 0; xmem_ready = 0; mem_wstrb = 0;
        if (!done) chk("no_completion", 0, 1);
    endtask

    // Access + model prediction + checks.
    task automatic do_acc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                          input int xd, input logic [31:0] xdat, input bit chk_rd);
        logic [31:0] rd, exp;
        int lat, xv, elat, exv;
        exp = 0; exv = 0; elat = 2;
        if (a < 32'd1024) begin
            exp = m_ram[a[5:2]];
            m_ram[a[5:2]] = merge(m_ram[a[5:2]], wd, st);
        end else if (a[31:4] == GB[31:4]) begin
            case (a[3:2])
                2'd0: begin exp = gpio_i; m_gpo = merge(m_gpo, wd, st); end
                2'd1: begin exp = m_oe;   m_oe  = merge(m_oe, wd, st); end
`ifdef PICOSOC_GPIO_IRQ_EN
                2'd3: begin exp = m_mask; m_mask = merge(m_mask, wd, st); end
`endif
                default: exp = 0;
            endcase
        end else if (a[31:30] == 2'b10) begin
            if (xd >= 0 && xd + 1 <= TMO + 1) begin elat = xd + 1; exp = xdat; end
            else begin elat = TMO + 1; exp = ERR; m_err = 1; end
            exv = elat - 1;
        end else begin
            elat = TMO + 1; exp = ERR; m_err = 1;
        end
        bus_xfer(a, wd, st, xd, xdat, rd, lat, xv);
        chk("latency", lat, elat);
        chk("xmem_valid_cycles", xv, exv);
        if (chk_rd && st == 0) chk("rdata", rd, exp);
        chk("gpio_o", gpio_o, m_gpo);
        chk("gpio_oe", gpio_oe, m_oe);
        chk("bus_err", 32'(bus_err), 32'(m_err));
    endtask

    initial begin
        int c0, k;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_ready", 32'(mem_ready), 0);
        chk("rst_gpio_o", gpio_o, 0);
        chk("rst_gpio_oe", gpio_oe, 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_irq", 32'(irq), 0);

        // Prefill the RAM words used below so the model knows every value.
        for (int w = 0; w < 16; w++) do_acc(32'(w) << 2, $urandom, 4'hF, -1, 0, 1);

        // Partial write keeps the upper half; read returns it merged.
        do_acc(32'h10, 32'h1234_5678, 4'b0011, -1, 0, 1);
        do_acc(32'h10, 0, 4'b0000, -1, 0, 1);
        chk("rdata_hold", mem_rdata, m_ram[4]);

        // GPIO registers and input synchroniser
        do_acc(GB, 32'hA5, 4'hF, -1, 0, 1);
        do_acc(GB + 4, 32'hFF, 4'hF, -1, 0, 1);
        chk("gpio_o_a5", gpio_o, 32'hA5);
        @(posedge clk); #1 gpio_i = 32'h3C;
        bus_xfer(GB, 0, 0, -1, 0, a, k, c0);
        chk("gpio_sync_early", a, 32'h0);
        do_acc(GB, 0, 0, -1, 0, 1);
        do_acc(GB, 32'h1234_5600, 4'b0010, -1, 0, 1);
`ifndef PICOSOC_GPIO_IRQ_EN
        do_acc(GB + 8, 32'hFFFF_FFFF, 4'hF, -1, 0, 1);
        do_acc(GB + 12, 32'hFFFF_FFFF, 4'hF, -1, 0, 1);
        do_acc(GB + 8, 0, 0, -1, 0, 1);
        do_acc(GB + 12, 0, 0, -1, 0, 1);
`endif

        // EXT read answered after 7 cycles
        do_acc(32'h8010_0000, 0, 0, 7, 32'hCAFE_F00D, 1);
        chk("xmem_addr", 32'(xmem_addr), 32'h10_0000);
        // xmem_ready coincides with the timeout cycle: ext wins, no error
        do_acc(32'h8000_0200, 0, 0, TMO, 32'h0BAD_CAFE, 1);
        // Unmapped read times out and sets the sticky error
        do_acc(32'h4000_0000, 0, 0, -1, 0, 1);
        do_acc(32'h4000_0010, 32'h5555_5555, 4'hF, -1, 0, 1);
        // Hung EXT access
        do_acc(32'h8000_0300, 0, 0, -1, 0, 1);

        // Randomized mix
        gpio_i = $urandom;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: do_acc((32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)), $urandom,
                          ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, -1, 0, 1);
                1: do_acc(GB | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3)),
                          $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, -1, 0, 1);
                default: do_acc(32'h8000_0000 | ($urandom & 32'h3FFF_FFFC), $urandom, 4'h0,
                                $urandom_range(0, 10), $urandom, 1);
            endcase
        end

        // Reset while an EXT read is pending
        @(posedge clk); #1;
        mem_valid = 1; mem_addr = 32'h8000_0040; mem_wstrb = 0; xmem_ready = 0;
        c0 = rdy_cnt;
        repeat (3) @(posedge clk); #1;
        chk("xmem_valid_pending", 32'(xmem_valid), 1);
        reset = 1; mem_valid = 0;
        @(posedge clk); #1 reset = 0;
        repeat (4) @(posedge clk); #1;
        chk("rst_no_ready", 32'(rdy_cnt - c0), 0);
        m_gpo = 0; m_oe = 0; m_err = 0; m_mask = 0;
        chk("rst2_gpio_o", gpio_o, 0);
        chk("rst2_gpio_oe", gpio_oe, 0);
        chk("rst2_bus_err", 32'(bus_err), 0);
        chk("rst2_irq", 32'(irq), 0);
        do_acc(32'h10, 0, 0, -1, 0, 1);

`ifdef PICOSOC_GPIO_IRQ_EN
        gpio_i = 0;
        repeat (4) @(posedge clk);
        do_acc(GB + 8, 32'hFFFF_FFFF, 4'hF, -1, 0, 0);
        do_acc(GB + 12, 32'h1, 4'hF, -1, 0, 1);
        repeat (3) @(posedge clk); #1;
        chk("irq_idle", 32'(irq), 0);
        gpio_i = 32'h1;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (irq === 1'b1) break;
        end
        chk("irq_rise_within_4", 32'(k <= 4), 1);
        do_acc(GB + 8, 32'h1, 4'hF, -1, 0, 0);
        chk("irq_cleared", 32'(irq), 0);
        do_acc(GB + 12, 0, 0, -1, 0, 1);
`else
        gpio_i = 0;
        repeat (3) @(posedge clk); #1 gpio_i = 32'hFFFF_FFFF;
        repeat (6) @(posedge clk); #1;
        chk("irq_tied_low", 32'(irq), 0);
`endif

        chk("no_double_ready", 32'(dbl), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/picosoc_memctl.md
Name: picosoc_memctl

Overview:
- Parametrised memory/peripheral slave for the picorv32 native memory interface, sitting between the CPU and its slaves.
- Decodes each transaction to one of four targets: on-chip RAM, a multi-register GPIO block, an external memory port (SPI flash controller), or nothing (unmapped).
- Merges ready/rdata back to the CPU.
- Unmapped or hung transactions complete via a bus timeout with an error flag.

Parameters:
- MEM_WORDS, 256, RAM depth in 32-bit words; RAM occupies 0x0 .. 4*MEM_WORDS-1.
- GPIO_WIDTH, 32, number of GPIO pins, 1..32.
- GPIO_BASE, 32'hC000_0000, base address of the GPIO register window (16 bytes).
- TIMEOUT, 64, cycles an access may stay pending before forced completion, >=4.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_valid  in  1  CPU request valid, held until mem_ready
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid when mem_ready=1
- xmem_valid  out  1  external request; = mem_valid && addr[31:30]==2'b10 && !mem_ready
- xmem_addr  out  24  mem_addr[23:0]
- xmem_ready  in  1  external completion
- xmem_rdata  in  32  external read data
- gpio_i  in  GPIO_WIDTH  pin inputs, asynchronous
- gpio_o  out  GPIO_WIDTH  pin output values
- gpio_oe  out  GPIO_WIDTH  pin output enables
- bus_err  out  1  sticky; set on timeout, cleared only by reset
- irq  out  1  GPIO interrupt (only with GPIO_IRQ_EN)

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset clears mem_ready, gpio_o, gpio_oe, bus_err, irq, the timeout counter and the synchroniser flops.
  - Reset does not clear RAM contents.
  - Reset asserted mid-access abandons the access; no mem_ready is issued for it.
- Decode:
  - Targets are mutually exclusive: RAM (addr < 4*MEM_WORDS), GPIO (addr[31:4]==GPIO_BASE[31:4]), EXT (addr[31:30]==2'b10), else unmapped.
  - Addresses are word-aligned; addr[1:0] is ignored.
- RAM access:
  - Registered, one-cycle latency: cycle N valid with mem_ready=0; cycle N+1 mem_ready=1.
  - Read data is the pre-write word.
  - Byte strobes are honoured individually.
- GPIO register window (one-cycle latency, byte strobes honoured):
  - +0x0 DATA: write updates gpio_o; read returns {zero-pad, synced gpio_i}.
  - +0x4 DIR: read/write gpio_oe.
  - +0x8 IRQ_STAT and +0xC IRQ_MASK: see Optional Feature.
  - Bits above GPIO_WIDTH read 0; writes to them are ignored.
- gpio_i synchronisation:
  - Two-flop synchroniser before any use.
  - A pin change is visible to reads 2 cycles after the change.
- EXT access:
  - mem_ready = xmem_ready, combinational pass-through.
  - mem_rdata = xmem_rdata while xmem_ready is high.
  - xmem_valid drops in the cycle mem_ready is high.
- Timeout:
  - Counter increments each cycle mem_valid=1 && mem_ready=0, and clears on mem_ready or when mem_valid=0.
  - When it reaches TIMEOUT-1: next cycle mem_ready=1, mem_rdata=ERR_RDATA, bus_err<=1.
  - Unmapped accesses therefore complete after exactly TIMEOUT+1 cycles.
  - Writes to unmapped addresses are dropped.
  - If EXT xmem_ready arrives in the same cycle the timeout fires, xmem_ready wins and bus_err is not set.
- mem_ready is never high for two consecutive cycles.
- mem_rdata holds its last value when mem_ready=0.

Optional Feature:
- Macro: PICOSOC_GPIO_IRQ_EN.
- When defined:
  - Rising edges on synced gpio_i set the corresponding IRQ_STAT bits.
  - IRQ_STAT write is W1C; if a new edge and a W1C on the same bit coincide, the bit stays set.
  - IRQ_MASK is read/write, reset 0.
  - irq = |(IRQ_STAT & IRQ_MASK), registered.
- When undefined:
  - +0x8 and +0xC read 0; writes are ignored.
  - irq is tied 0.

Test Plan:
- Write 0x1234_5678 to 0x10 with wstrb=4'b0011, then read 0x10 -> mem_ready 1 cycle after each valid; read returns 0xXXXX_5678 with upper half unchanged from prior contents.
- Write 0xA5 to GPIO_BASE and 0xFF to GPIO_BASE+4 -> gpio_o=0xA5, gpio_oe=0xFF; drive gpio_i=0x3C -> read GPIO_BASE returns 0x3C from the 3rd cycle after the change.
- Read 0x8010_0000 with xmem_ready asserted 7 cycles after valid, xmem_rdata=0xCAFEF00D -> xmem_valid high for exactly 7 cycles, mem_ready same cycle, mem_rdata=0xCAFEF00D, bus_err=0.
- Read 0x4000_0000 (unmapped), TIMEOUT=64 -> mem_ready at cycle 65, mem_rdata=0xDEADBEEF, bus_err=1 and it stays 1 after subsequent good accesses.
- Assert reset for 1 cycle while an EXT read is pending -> mem_ready never pulses for that access; gpio_o=0, gpio_oe=0, bus_err=0; RAM word at 0x10 retains its value.
- With PICOSOC_GPIO_IRQ_EN: mask=0x1, pulse gpio_i[0] 0->1 -> irq=1 within 4 cycles; write 0x1 to +0x8 -> irq=0 the next cycle.
